// File: rtl/zmips_seq_alu.sv
// Sequential ALU: single-cycle add/sub/logic, bit-serial shifts, optional shift-add multiplier.
// Define ZMIPS_SEQ_ALU_MUL_EN to build the multiplier (op 12); otherwise op 12 behaves as undefined.
module zmips_seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             cout
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_EOR = 4'd6;
    localparam logic [3:0] OP_SLL = 4'd8;
    localparam logic [3:0] OP_SRL = 4'd9;
    localparam logic [3:0] OP_SRA = 4'd11;
`ifdef ZMIPS_SEQ_ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd12;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_y;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
`ifdef ZMIPS_SEQ_ALU_MUL_EN
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
`endif

    logic [WIDTH-1:0] w_bop;
    logic [WIDTH:0]   w_sum;
    logic [SHW-1:0]   w_amt;
    logic             w_is_shift;
    logic [WIDTH-1:0] w_y1;
    logic             w_c1;

    // SUB reuses the adder as a + ~b + 1 so cout reads as "no borrow"
    assign w_bop      = (op == OP_SUB) ? ~b : b;
    assign w_sum      = {1'b0, a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, (op == OP_SUB)};
    assign w_amt      = b[SHW-1:0];
    assign w_is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);

    always_comb begin
        w_y1 = '0;
        w_c1 = 1'b0;
        case (op)
            OP_ADD, OP_SUB: {w_c1, w_y1} = w_sum;
            OP_AND:         w_y1 = a & b;
            OP_OR:          w_y1 = a | b;
            OP_EOR:         w_y1 = a ^ b;
            OP_SLL, OP_SRL, OP_SRA: w_y1 = a;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op        <= '0;
            r_y         <= '0;
            r_cout      <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
`ifdef ZMIPS_SEQ_ALU_MUL_EN
            r_mcand     <= '0;
            r_mplier    <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op       <= op;
                        r_in_ready <= 1'b0;
                        r_cout     <= 1'b0;
                        if (w_is_shift && (w_amt != '0)) begin
                            r_y     <= a;
                            r_cnt   <= CW'(w_amt);
                            r_state <= BUSY;
                        end
`ifdef ZMIPS_SEQ_ALU_MUL_EN
                        else if (op == OP_MUL) begin
                            r_y      <= '0;
                            r_mcand  <= a;
                            r_mplier <= b;
                            r_cnt    <= CW'(WIDTH);
                            r_state  <= BUSY;
                        end
`endif
                        else begin
                            r_y         <= w_y1;
                            r_cout      <= w_c1;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                    // one bit per cycle; cout tracks the bit most recently shifted out
                    case (r_op)
                        OP_SLL: begin
                            r_y    <= r_y << 1;
                            r_cout <= r_y[WIDTH-1];
                        end
                        OP_SRL: begin
                            r_y    <= r_y >> 1;
                            r_cout <= r_y[0];
                        end
                        OP_SRA: begin
                            r_y    <= {r_y[WIDTH-1], r_y[WIDTH-1:1]};
                            r_cout <= r_y[0];
                        end
`ifdef ZMIPS_SEQ_ALU_MUL_EN
                        OP_MUL: begin
                            if (r_mplier[0]) begin
                                r_y <= r_y + r_mcand;
                            end
                            r_mcand  <= r_mcand << 1;
                            r_mplier <= r_mplier >> 1;
                        end
`endif
                        default: ;
                    endcase
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign cout      = r_cout;
    assign zero      = ~|r_y;

endmodule

// File: tb/tb_zmips_seq_alu.sv
// Bench for zmips_seq_alu: transaction-level reference model plus directed literal cases.
// Follows ZMIPS_SEQ_ALU_MUL_EN to choose the expected behaviour of op 12.
module tb_zmips_seq_alu;
    localparam int W = 32;
`ifdef ZMIPS_SEQ_ALU_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] y;
    logic         zero;
    logic         cout;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    zmips_seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .zero(zero), .cout(cout)
    );

    // Returns {cout, y} straight from the operation definitions
    function automatic logic [W:0] ref_result(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
        int           amt;
        logic [63:0]  p;
        logic [W-1:0] r;
        logic         c;
        amt = int'(z % W);
        r = '0;
        c = 1'b0;
        case (o)
            4'd0: begin p = 64'(x) + 64'(z); r = p[W-1:0]; c = p[W]; end
            4'd1: begin r = x - z; c = (x >= z); end
            4'd2: r = x & z;
            4'd4: r = x | z;
            4'd6: r = x ^ z;
            4'd8: begin r = x << amt; if (amt != 0) c = x[W-amt]; end
            4'd9: begin r = x >> amt; if (amt != 0) c = x[amt-1]; end
            4'd11: begin r = W'($signed(x) >>> amt); if (amt != 0) c = x[amt-1]; end
            4'd12: if (MUL_ON) begin p = 64'(x) * 64'(z); r = p[W-1:0]; end
            default: ;
        endcase
        return {c, r};
    endfunction

    function automatic int ref_lat(input logic [3:0] o, input logic [W-1:0] z);
        if (o == 4'd8 || o == 4'd9 || o == 4'd11) return int'(z % W) + 1;
        if (o == 4'd12 && MUL_ON) return W + 1;
        return 1;
    endfunction

    // Transaction model: result pending for (latency-1) edges, then held until taken
    bit           m_valid = 1'b0;
    int           m_wait = 0;
    logic [W-1:0] m_y = '0;
    logic         m_c = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        logic [W:0] rr;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_wait  = 0;
            m_y     = '0;
            m_c     = 1'b0;
        end else if (m_valid) begin
            if (out_ready) m_valid = 1'b0;
        end else if (m_wait > 0) begin
            m_wait = m_wait - 1;
            if (m_wait == 0) m_valid = 1'b1;
        end else if (in_valid) begin
            rr      = ref_result(op, a, b);
            m_y     = rr[W-1:0];
            m_c     = rr[W];
            m_wait  = ref_lat(op, b) - 1;
            if (m_wait == 0) m_valid = 1'b1;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] z,
                         input int hold, input logic [W-1:0] ey, input logic ec,
                         input int elat, input string nm);
        int lat;
        bit got;
        @(posedge clk); #1;
        check({nm, "_rdy"}, 64'(in_ready), 64'(1));
        op = o; a = x; b = z; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; op = 4'($urandom_range(0, 15));
        lat = 1;
        got = out_valid;
        while (!got && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            got = out_valid;
        end
        check({nm, "_done"}, 64'(got), 64'(1));
        check({nm, "_lat"}, 64'(lat), 64'(elat));
        check({nm, "_y"}, 64'(y), 64'(ey));
        check({nm, "_cout"}, 64'(cout), 64'(ec));
        check({nm, "_zero"}, 64'(zero), 64'(ey == '0));
        // stray requests while the result is held must be ignored
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom; op = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
            check({nm, "_hold_y"}, 64'(y), 64'(ey));
            check({nm, "_hold_rdy"}, 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check({nm, "_taken_vld"}, 64'(out_valid), 64'(0));
        check({nm, "_taken_rdy"}, 64'(in_ready), 64'(1));
    endtask

    initial begin
        fork
            begin : cmp
                forever begin
                    @(negedge clk);
                    if (rst_n === 1'b1) begin
                        check("cyc_in_ready", 64'(in_ready), 64'(!(m_valid || m_wait > 0)));
                        check("cyc_out_valid", 64'(out_valid), 64'(m_valid));
                        if (m_valid) begin
                            check("cyc_y", 64'(y), 64'(m_y));
                            check("cyc_cout", 64'(cout), 64'(m_c));
                            check("cyc_zero", 64'(zero), 64'(m_y == '0));
                        end
                    end
                end
            end
            begin : main
                logic [W:0] rr;
                logic [3:0] ro;
                logic [W-1:0] rx, rz;
                int seen;
                #22;
                check("rst_out_valid", 64'(out_valid), 64'(0));
                check("rst_y", 64'(y), 64'(0));
                check("rst_zero", 64'(zero), 64'(1));
                check("rst_cout", 64'(cout), 64'(0));
                rst_n = 1'b1;
                #1;
                check("rst_in_ready", 64'(in_ready), 64'(1));

                do_op(4'd0, 32'hFFFF_FFFF, 32'h1, 0, 32'h0, 1'b1, 1, "add_wrap");
                do_op(4'd1, 32'd5, 32'd7, 0, 32'hFFFF_FFFE, 1'b0, 1, "sub_borrow");
                do_op(4'd1, 32'd7, 32'd5, 0, 32'd2, 1'b1, 1, "sub_ok");
                do_op(4'd11, 32'h8000_0000, 32'h24, 0, 32'hF800_0000, 1'b0, 5, "sra4");
                do_op(4'd8, 32'h1234_5678, 32'h0, 0, 32'h1234_5678, 1'b0, 1, "sll0");
                do_op(4'd8, 32'h8000_0001, 32'd33, 0, 32'h2, 1'b1, 2, "sll1");
                do_op(4'd9, 32'h3, 32'd1, 0, 32'h1, 1'b1, 2, "srl1");
                do_op(4'd6, 32'hF0F0_1234, 32'h0FF0_1234, 10, 32'hFF00_0000, 1'b0, 1, "eor_bp");
                do_op(4'd3, 32'hDEAD_BEEF, 32'h1, 0, 32'h0, 1'b0, 1, "undef3");
                if (MUL_ON)
                    do_op(4'd12, 32'h1_0001, 32'h1_0001, 0, 32'h0002_0001, 1'b0, 33, "mul");
                else
                    do_op(4'd12, 32'h1_0001, 32'h1_0001, 0, 32'h0, 1'b0, 1, "mul_off");

                // reset ten cycles into a multiply; result must be discarded
                @(posedge clk); #1;
                op = 4'd12; a = 32'h1_0001; b = 32'h1_0001; in_valid = 1'b1;
                @(posedge clk); #1;
                in_valid = 1'b0;
                repeat (9) @(posedge clk);
                #3;
                rst_n = 1'b0;
                #1;
                check("arst_out_valid", 64'(out_valid), 64'(0));
                check("arst_y", 64'(y), 64'(0));
                check("arst_zero", 64'(zero), 64'(1));
                check("arst_cout", 64'(cout), 64'(0));
                #10;
                rst_n = 1'b1;
                seen = 0;
                repeat (40) begin
                    @(negedge clk);
                    if (out_valid) seen++;
                end
                check("arst_no_result", 64'(seen), 64'(0));

                for (int i = 0; i < 80; i++) begin
                    ro = 4'($urandom_range(0, 15));
                    rx = $urandom;
                    rz = $urandom;
                    if (i % 4 == 0) rx = '0;
                    rr = ref_result(ro, rx, rz);
                    do_op(ro, rx, rz, $urandom_range(0, 3), rr[W-1:0], rr[W], ref_lat(ro, rz), "rnd");
                end
                repeat (3) @(posedge clk);
            end
        join_any
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/zmips_seq_alu.md
ZMIPS_SEQ_ALU -- requirements
Module: zmips_seq_alu

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width in bits (legal 8..64, power of two).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 a, b  input  WIDTH each  operands, sampled on accept.
REQ-007 op  input  4  operation code, sampled on accept.
REQ-008 out_valid  output  1  result registers hold a valid result.
REQ-009 out_ready  input  1  consumer takes result this cycle.
REQ-010 y  output  WIDTH  result.
REQ-011 zero, cout  output  1 each  y==0 flag; carry/shift-out flag.

Function
REQ-012 Op codes: 0 ADD, 1 SUB, 2 AND, 4 OR, 6 EOR, 8 SLL, 9 SRL, 11 SRA, 12 MUL (low WIDTH bits of product); codes 0-7 keep prior 3-bit ALU encoding.
REQ-013 Undefined codes SHALL complete in 1 cycle with y=0, cout=0, zero=1.
REQ-014 FSM states IDLE, BUSY, DONE; in_ready=1 only in IDLE; accept = in_valid & in_ready.
REQ-015 ADD/SUB/AND/OR/EOR/undefined: accept in IDLE -> DONE next edge; out_valid high the cycle after accept (latency 1).
REQ-016 SUB computes a + ~b + 1; cout = adder carry-out (1 = no borrow); ADD cout = carry-out; logic ops cout=0.
REQ-017 Shifts: amount = b[log2(WIDTH)-1:0]; upper b bits ignored; one bit per cycle in BUSY; amount 0 -> DONE directly, y=a, cout=0; latency = amount+1 cycles (min 1).
REQ-018 Shift cout = last bit shifted out; SRA replicates a[WIDTH-1].
REQ-019 MUL: shift-add, one multiplier bit per cycle, WIDTH cycles in BUSY; latency WIDTH+1; cout=0; product modulo 2^WIDTH.
REQ-020 DONE: out_valid=1, y/zero/cout stable until out_ready=1; on out_valid & out_ready -> IDLE next edge.
REQ-021 No overlap: new request SHALL NOT be accepted in the cycle the result is taken; in_ready rises the following cycle.
REQ-022 zero = ~|y, derived from registered y, valid whenever out_valid=1.
REQ-023 Operands and op changing while BUSY/DONE SHALL NOT affect the result.
REQ-024 Iteration counter width = log2(WIDTH)+1 bits; no wrap before termination.

Reset
REQ-025 rst_n low: FSM -> IDLE, y=0, cout=0, zero=1, out_valid=0, in_ready=1 (after release), counter=0, immediately and independent of clk.
REQ-026 Reset mid-BUSY or mid-DONE SHALL discard the operation; no result emitted after release.

Configuration
REQ-027 Macro ZMIPS_SEQ_ALU_MUL_EN: defined -> MUL (op 12) per REQ-019; undefined -> multiplier logic absent, op 12 treated as undefined per REQ-013.

Verification
REQ-028 WIDTH=32, ADD a=0xFFFFFFFF b=1, out_ready=1 -> out_valid 1 cycle after accept, y=0, zero=1, cout=1.
REQ-029 SUB a=5 b=7 -> y=0xFFFFFFFE, cout=0, zero=0; SUB a=7 b=5 -> y=2, cout=1.
REQ-030 SRA a=0x80000000 b=0x24 (amount 4) -> out_valid exactly 5 cycles after accept, y=0xF8000000, cout=0; SLL b=0 -> latency 1, y=a.
REQ-031 MUL a=0x10001 b=0x10001, MUL_EN defined -> latency 33, y=0x00020001, cout=0; MUL_EN undefined -> latency 1, y=0, zero=1.
REQ-032 Backpressure: out_ready=0 for 10 cycles in DONE -> y/flags held, in_ready=0; new in_valid ignored until cycle after out_ready handshake.
REQ-033 rst_n pulsed low during MUL BUSY cycle 10 -> outputs at reset values asynchronously; no out_valid after release until a new accept.
